// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared encodings and constants for the time-multiplexed bit-pattern
// detector: detector state codes, scheduler state codes, byte width and the
// width of a per-byte hit count.
package seq_detect_pkg;

    localparam int BYTE_W = 8;
    localparam int HIT_W  = 4;   // holds 0..8 hits per byte

    // Detector engine states. Encodings 3'b101..3'b111 are unused and
    // recover to S0.
    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } det_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        STORE = 2'b11
    } sched_state_e;

endpackage

// File: rtl/seq_detect_step.sv
// seq_detect_step
// One combinational step of the serial Mealy detector.
// Ports:
//   state      in  3  current detector state
//   x          in  1  input bit
//   next_state out 3  state after consuming x
//   y          out 1  hit flag for this bit
module seq_detect_step
    import seq_detect_pkg::*;
(
    input  logic [2:0] state,
    input  logic       x,
    output logic [2:0] next_state,
    output logic       y
);

    always_comb begin
        next_state = S0;
        y          = 1'b0;
        case (state)
            S0: next_state = x ? S1 : S0;
            S1: next_state = x ? S3 : S2;
            S2: next_state = x ? S3 : S0;
            S3: begin
                next_state = x ? S3 : S4;
                y          = x;
            end
            S4: begin
                next_state = x ? S3 : S0;
                y          = x;
            end
            default: begin
                next_state = S0;
                y          = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
// Shares one serial detector engine among NCH byte channels. A round-robin
// arbiter grants one pending byte, the channel's saved detector context is
// restored, the byte is shifted through MSB-first, then the context and a
// saturating per-channel hit counter are written back.
//
// Handshake: req_ready[i] is a one-cycle pulse raised in IDLE for the granted
// channel while its req_valid[i] is high; the byte on req_data is taken in
// that same cycle, so the source may change or drop it afterwards.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_valid    per-channel byte pending
//   req_data     per-channel byte, channel i in [8i+7:8i]
//   req_ready    one-hot accept pulse
//   ch_clr       per-channel synchronous clear of context and counter
//   res_valid    one-cycle pulse when a byte finishes (STORE)
//   res_ch       channel of the finished byte (held until next STORE)
//   res_hits     hits in the finished byte (held until next STORE)
//   hit_cnt      per-channel saturating hit counters, channel i in [CWi+CW-1:CWi]
//   busy         scheduler not in IDLE
//   dbg_state    current scheduler state
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req_valid,
    input  logic [8*NCH-1:0]      req_data,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH-1:0]        ch_clr,
    output logic                  res_valid,
    output logic [2:0]            res_ch,
    output logic [HIT_W-1:0]      res_hits,
    output logic [CW*NCH-1:0]     hit_cnt,
    output logic                  busy,
    output sched_state_e          dbg_state
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = CW + HIT_W;
    localparam logic [CW-1:0] CNT_MAX = '1;

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [BYTE_W-1:0]     shreg_q, shreg_d;
    logic [2:0]            eng_q, eng_d;
    logic [HIT_W-1:0]      acc_q, acc_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  clr_seen_q, clr_seen_d;
    logic [2:0]            res_ch_q, res_ch_d;
    logic [HIT_W-1:0]      res_hits_q, res_hits_d;
    logic [2:0]            ctx_q [NCH];
    logic [2:0]            ctx_d [NCH];
    logic [CW-1:0]         cnt_q [NCH];
    logic [CW-1:0]         cnt_d [NCH];

    logic [BYTE_W-1:0]     req_byte [NCH];
    logic                  any_valid;
    logic [IW-1:0]         pick;
    logic [2:0]            step_next;
    logic                  step_y;
    logic [SW-1:0]         cnt_sum;
    logic [CW-1:0]         cnt_sat;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign req_byte[g]          = req_data[8*g +: 8];
        assign hit_cnt[CW*g +: CW]  = cnt_q[g];
    end

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!any_valid && req_valid[IW'(idx)]) begin
                any_valid = 1'b1;
                pick      = IW'(idx);
            end
        end
    end

    seq_detect_step u_step (
        .state      (eng_q),
        .x          (shreg_q[BYTE_W-1]),
        .next_state (step_next),
        .y          (step_y)
    );

    assign cnt_sum = SW'(cnt_q[gnt_q]) + SW'(res_hits_q);
    assign cnt_sat = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CW-1:0];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        shreg_d    = shreg_q;
        eng_d      = eng_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        clr_seen_d = clr_seen_q;
        res_ch_d   = res_ch_q;
        res_hits_d = res_hits_q;
        ctx_d      = ctx_q;
        cnt_d      = cnt_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[pick] = 1'b1;
                    gnt_d           = pick;
                    shreg_d         = req_byte[pick];
                    clr_seen_d      = 1'b0;
                    state_d         = LOAD;
                end
            end
            LOAD: begin
                eng_d      = ctx_q[gnt_q];
                acc_d      = '0;
                bit_cnt_d  = '0;
                clr_seen_d = clr_seen_q | ch_clr[gnt_q];
                state_d    = SHIFT;
            end
            SHIFT: begin
                eng_d      = step_next;
                shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
                acc_d      = acc_q + HIT_W'(step_y);
                bit_cnt_d  = bit_cnt_q + 3'd1;
                clr_seen_d = clr_seen_q | ch_clr[gnt_q];
                if (bit_cnt_q == 3'd7) begin
                    // Result is registered here so it is visible during STORE.
                    res_hits_d = acc_d;
                    res_ch_d   = 3'(gnt_q);
                    state_d    = STORE;
                end
            end
            STORE: begin
                // A clear seen at any point of service discards the writeback.
                if (!(clr_seen_q || ch_clr[gnt_q])) begin
                    ctx_d[gnt_q] = eng_q;
                    cnt_d[gnt_q] = cnt_sat;
                end
                rr_ptr_d = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clears are applied last so they win over a same-cycle writeback.
        for (int i = 0; i < NCH; i++) begin
            if (ch_clr[i]) begin
                ctx_d[i] = S0;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            shreg_q    <= '0;
            eng_q      <= S0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            clr_seen_q <= 1'b0;
            res_ch_q   <= '0;
            res_hits_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= S0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            shreg_q    <= shreg_d;
            eng_q      <= eng_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            clr_seen_q <= clr_seen_d;
            res_ch_q   <= res_ch_d;
            res_hits_q <= res_hits_d;
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= ctx_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign res_valid = (state_q == STORE);
    assign res_ch    = res_ch_q;
    assign res_hits  = res_hits_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
